// File: rtl/aperture_bank.sv
// Memory-aperture unit: NUM_AP programmable descriptors, combinational page claim,
// and a two-stage translation pipeline to SDRAM byte addresses (linear or clipped 2-D).

module aperture_desc #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        off,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] base,
    output logic [7:0]        lo,
    output logic [7:0]        hi,
    output logic [7:0]        stride,
    output logic [15:0]       x,
    output logic [15:0]       y,
    output logic [15:0]       w,
    output logic [15:0]       h,
    output logic              en,
    output logic              mode
);
    // 32-bit view of base: bits at or above ADDR_W are dropped on write and read as 0.
    logic [31:0] base32;
    assign base32 = 32'(base);

    always_ff @(posedge clk) begin
        if (rst) begin
            base   <= '0;
            lo     <= '0;
            hi     <= '0;
            stride <= '0;
            x      <= '0;
            y      <= '0;
            w      <= '0;
            h      <= '0;
            en     <= 1'b0;
            mode   <= 1'b0;
        end else if (we) begin
            case (off)
                4'h0: base <= ADDR_W'({wdata, base32[23:0]});
                4'h1: base <= ADDR_W'({base32[31:24], wdata, base32[15:0]});
                4'h2: base <= ADDR_W'({base32[31:16], wdata, base32[7:0]});
                4'h3: base <= ADDR_W'({base32[31:8], wdata});
                4'h4: lo <= wdata;
                4'h5: hi <= wdata;
                4'h6: stride <= wdata;
                4'h7: x[7:0] <= wdata;
                4'h8: x[15:8] <= wdata;
                4'h9: y[7:0] <= wdata;
                4'hA: y[15:8] <= wdata;
                4'hB: w[7:0] <= wdata;
                4'hC: w[15:8] <= wdata;
                4'hD: h[7:0] <= wdata;
                4'hE: h[15:8] <= wdata;
                default: begin
                    en   <= wdata[0];
                    mode <= wdata[1];
                end
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (off)
            4'h0: rdata = base32[31:24];
            4'h1: rdata = base32[23:16];
            4'h2: rdata = base32[15:8];
            4'h3: rdata = base32[7:0];
            4'h4: rdata = lo;
            4'h5: rdata = hi;
            4'h6: rdata = stride;
            4'h7: rdata = x[7:0];
            4'h8: rdata = x[15:8];
            4'h9: rdata = y[7:0];
            4'hA: rdata = y[15:8];
            4'hB: rdata = w[7:0];
            4'hC: rdata = w[15:8];
            4'hD: rdata = h[7:0];
            4'hE: rdata = h[15:8];
            default: rdata = {6'b0, mode, en};
        endcase
    end
endmodule

module aperture_bank #(
    parameter int          NUM_AP   = 4,
    parameter int          ADDR_W   = 24,
    parameter logic [7:0]  CFG_PAGE = 8'hD6,
    localparam int         IW       = (NUM_AP > 1) ? $clog2(NUM_AP) : 1
) (
    input  logic              clk,
    input  logic              a8_rst,
    input  logic              a8_rw_n,
    input  logic [7:0]        a8_data,
    input  logic [15:0]       addr,
    input  logic              aValid,
    input  logic              wValid,
    output logic              hit,
    output logic [IW-1:0]     hitIndex,
    output logic [7:0]        cfgData,
    output logic              cfgValid,
    output logic              xlValid,
    output logic [ADDR_W-1:0] xlAddr,
    output logic [IW-1:0]     xlIndex,
    output logic              xlClip
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [IW-1:0]     idx;
        logic [15:0]       off;
        logic [ADDR_W-1:0] base;
        logic [7:0]        stride;
        logic [15:0]       x;
        logic [15:0]       y;
        logic [15:0]       w;
        logic [15:0]       h;
        logic              mode;
    } s1_t;

    logic [7:0] page;
    logic [3:0] sel;
    logic       cfg_match, wr_en, rd_en;
    assign page      = addr[15:8];
    assign sel       = addr[7:4];
    assign cfg_match = (page == CFG_PAGE) && ({1'b0, sel} < 5'(NUM_AP));
    assign wr_en     = !a8_rw_n && wValid && cfg_match;
    assign rd_en     = a8_rw_n && aValid && cfg_match;

    logic [NUM_AP-1:0]             we_a, en_a, mode_a, claim;
    logic [NUM_AP-1:0][ADDR_W-1:0] base_a;
    logic [NUM_AP-1:0][7:0]        lo_a, hi_a, stride_a, rdata_a;
    logic [NUM_AP-1:0][15:0]       x_a, y_a, w_a, h_a;

    generate
        for (genvar i = 0; i < NUM_AP; i++) begin : g_ap
            aperture_desc #(.ADDR_W(ADDR_W)) u_desc (
                .clk(clk), .rst(a8_rst), .we(we_a[i]), .off(addr[3:0]), .wdata(a8_data),
                .rdata(rdata_a[i]), .base(base_a[i]), .lo(lo_a[i]), .hi(hi_a[i]),
                .stride(stride_a[i]), .x(x_a[i]), .y(y_a[i]), .w(w_a[i]), .h(h_a[i]),
                .en(en_a[i]), .mode(mode_a[i])
            );
        end
    endgenerate

    logic [IW-1:0] win;
    logic [7:0]    rsel, lo_sel;
    s1_t           s_nxt, s1;

    always_comb begin
        we_a   = '0;
        claim  = '0;
        win    = '0;
        rsel   = 8'h00;
        lo_sel = 8'h00;
        s_nxt  = '0;
        for (int i = 0; i < NUM_AP; i++) begin
            we_a[i]  = wr_en && (sel == 4'(i));
            claim[i] = en_a[i] && (lo_a[i] <= page) && (page <= hi_a[i]) && (page != CFG_PAGE);
        end
        // Scan downward so the lowest claiming index is the one left standing.
        for (int i = NUM_AP - 1; i >= 0; i--)
            if (claim[i]) win = IW'(i);
        for (int i = 0; i < NUM_AP; i++) begin
            if (sel == 4'(i)) rsel = rdata_a[i];
            if (win == IW'(i)) begin
                lo_sel       = lo_a[i];
                s_nxt.base   = base_a[i];
                s_nxt.stride = stride_a[i];
                s_nxt.x      = x_a[i];
                s_nxt.y      = y_a[i];
                s_nxt.w      = w_a[i];
                s_nxt.h      = h_a[i];
                s_nxt.mode   = mode_a[i];
            end
        end
        s_nxt.idx = win;
        s_nxt.off = addr - {lo_sel, 8'h00};
    end

    assign hit      = aValid && (|claim);
    assign hitIndex = hit ? win : '0;

    // Stage-2 arithmetic works only from the stage-1 snapshot, never the live descriptors.
    logic [7:0]        row, col;
    logic [16:0]       yr, xc;
    logic [24:0]       prod;
    logic [33:0]       sum_lin, sum_2d;
    logic [ADDR_W-1:0] xl_addr_c;
    logic              xl_clip_c;

    always_comb begin
        row       = s1.off[15:8];
        col       = s1.off[7:0];
        yr        = {1'b0, s1.y} + {9'b0, row};
        xc        = {1'b0, s1.x} + {9'b0, col};
        prod      = {8'b0, yr} * {17'b0, s1.stride};
        sum_lin   = 34'(s1.base) + {18'b0, s1.off};
        sum_2d    = 34'(s1.base) + {1'b0, prod, 8'h00} + {17'b0, xc};
        xl_addr_c = s1.mode ? sum_2d[ADDR_W-1:0] : sum_lin[ADDR_W-1:0];
        xl_clip_c = s1.mode && (({8'b0, col} >= s1.w) || ({8'b0, row} >= s1.h));
    end

    logic [STAGES:1] vld_pipe;
    assign xlValid = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (a8_rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            cfgData  <= 8'hFF;
            cfgValid <= 1'b0;
            xlAddr   <= '0;
            xlIndex  <= '0;
            xlClip   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], hit};
            cfgValid <= rd_en;
            if (rd_en) cfgData <= rsel;
            if (hit) s1 <= s_nxt;
            if (vld_pipe[1]) begin
                xlAddr  <= xl_addr_c;
                xlIndex <= s1.idx;
                xlClip  <= xl_clip_c;
            end
        end
    end
endmodule

// File: tb/tb_aperture_bank.sv
// Randomised + directed bench for aperture_bank: a byte-image reference model feeds
// expectation queues, and a negedge monitor pops and compares whatever the DUT emits.

module tb_aperture_bank;
    localparam int         NUM_AP = 4;
    localparam int         ADDR_W = 24;
    localparam logic [7:0] CFG    = 8'hD6;
    localparam longint     AMASK  = (64'd1 << ADDR_W) - 1;

    logic        clk = 1'b0;
    logic        a8_rst, a8_rw_n, aValid, wValid;
    logic [7:0]  a8_data;
    logic [15:0] addr;
    logic        hit, cfgValid, xlValid, xlClip;
    logic [1:0]  hitIndex, xlIndex;
    logic [7:0]  cfgData;
    logic [ADDR_W-1:0] xlAddr;

    aperture_bank #(.NUM_AP(NUM_AP), .ADDR_W(ADDR_W), .CFG_PAGE(CFG)) dut (
        .clk(clk), .a8_rst(a8_rst), .a8_rw_n(a8_rw_n), .a8_data(a8_data), .addr(addr),
        .aValid(aValid), .wValid(wValid), .hit(hit), .hitIndex(hitIndex),
        .cfgData(cfgData), .cfgValid(cfgValid), .xlValid(xlValid), .xlAddr(xlAddr),
        .xlIndex(xlIndex), .xlClip(xlClip)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: the config space as a byte image; fields derived arithmetically.
    logic [7:0] img [16][16];

    typedef struct { int due; longint a; int idx; bit clip; } xl_t;
    typedef struct { int due; logic [7:0] d; } cf_t;
    xl_t xl_q[$];
    cf_t cf_q[$];

    function automatic void model_clear();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) img[i][j] = 8'h00;
    endfunction

    function automatic bit cfg_hit(input logic [15:0] a);
        return (a[15:8] == CFG) && (int'(a[7:4]) < NUM_AP);
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
        longint v;
        if (!cfg_hit(a)) return;
        v = longint'(d);
        if (a[3:0] == 4'h0) v = ((v << 24) & AMASK) >> 24;
        if (a[3:0] == 4'hF) v = v & 3;
        img[a[7:4]][a[3:0]] = 8'(v);
    endfunction

    function automatic longint f16(input int i, input int o);
        return longint'(img[i][o]) + 256 * longint'(img[i][o+1]);
    endfunction

    task automatic model_claim(input logic [15:0] a, output bit h, output int idx);
        int pg;
        pg  = int'(a[15:8]);
        h   = 0;
        idx = 0;
        for (int i = 0; i < NUM_AP; i++)
            if (!h && img[i][15][0] && int'(img[i][4]) <= pg && pg <= int'(img[i][5]) && pg != int'(CFG)) begin
                h   = 1;
                idx = i;
            end
    endtask

    task automatic model_xl(input logic [15:0] a, input int i, output longint ea, output bit ec);
        longint base, off, row, col;
        base = ((longint'(img[i][0]) << 24) + (longint'(img[i][1]) << 16) +
                (longint'(img[i][2]) << 8) + longint'(img[i][3])) & AMASK;
        off  = (longint'(a) - 256 * longint'(img[i][4])) & 64'hFFFF;
        if (!img[i][15][1]) begin
            ea = (base + off) & AMASK;
            ec = 0;
        end else begin
            row = off / 256;
            col = off % 256;
            ec  = (col >= f16(i, 11)) || (row >= f16(i, 13));
            ea  = (base + (f16(i, 9) + row) * longint'(img[i][6]) * 256 + f16(i, 7) + col) & AMASK;
        end
    endtask

    task automatic step(input bit rst, input bit rw_n, input logic [15:0] a,
                        input bit av, input bit wv, input logic [7:0] d);
        bit     h;
        int     idx;
        longint ea;
        bit     ec;
        a8_rst = rst; a8_rw_n = rw_n; addr = a; aValid = av; wValid = wv; a8_data = d;
        #1;
        model_claim(a, h, idx);
        h = h && av;
        chk("hit", hit, h);
        chk("hitIndex", hitIndex, h ? idx : 0);
        if (rst) begin
            // Anything not yet emitted by the coming edge is killed by the reset.
            while (xl_q.size() > 0 && xl_q[xl_q.size()-1].due > cyc) void'(xl_q.pop_back());
            while (cf_q.size() > 0 && cf_q[cf_q.size()-1].due > cyc) void'(cf_q.pop_back());
            model_clear();
        end else begin
            if (h) begin
                model_xl(a, idx, ea, ec);
                xl_q.push_back('{cyc + 2, ea, idx, ec});
            end
            if (rw_n && av && cfg_hit(a)) cf_q.push_back('{cyc + 1, img[a[7:4]][a[3:0]]});
            if (!rw_n && wv) model_write(a, d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d); step(0, 0, a, 0, 1, d); endtask
    task automatic acc(input logic [15:0] a); step(0, 1, a, 1, 0, 8'h00); endtask
    task automatic idle(); step(0, 1, 16'h1000, 0, 0, 8'h00); endtask

    task automatic prog(input int ap, input logic [31:0] base, input logic [7:0] lo,
                        input logic [7:0] hi, input logic [7:0] ctrl);
        logic [15:0] b;
        b = {CFG, 4'(ap), 4'h0};
        wr(b | 16'h0, base[31:24]);
        wr(b | 16'h1, base[23:16]);
        wr(b | 16'h2, base[15:8]);
        wr(b | 16'h3, base[7:0]);
        wr(b | 16'h4, lo);
        wr(b | 16'h5, hi);
        wr(b | 16'hF, ctrl);
    endtask

    // Monitor: decoupled from stimulus; checks timing via the due cycle in each entry.
    always @(negedge clk) begin
        xl_t e;
        cf_t c;
        if (xlValid === 1'b1) begin
            if (xl_q.size() == 0) chk("xl_unexpected", 1, 0);
            else begin
                e = xl_q.pop_front();
                chk("xl_due", cyc, e.due);
                chk("xlAddr", xlAddr, e.a);
                chk("xlIndex", xlIndex, e.idx);
                chk("xlClip", xlClip, e.clip);
            end
        end else if (xl_q.size() > 0 && xl_q[0].due <= cyc) begin
            chk("xl_missing", 0, 1);
            void'(xl_q.pop_front());
        end
        if (cfgValid === 1'b1) begin
            if (cf_q.size() == 0) chk("cfg_unexpected", 1, 0);
            else begin
                c = cf_q.pop_front();
                chk("cfg_due", cyc, c.due);
                chk("cfgData", cfgData, c.d);
            end
        end else if (cf_q.size() > 0 && cf_q[0].due <= cyc) begin
            chk("cfg_missing", 0, 1);
            void'(cf_q.pop_front());
        end
    end

    initial begin
        a8_rst = 1; a8_rw_n = 1; addr = 16'h0; aValid = 0; wValid = 0; a8_data = 8'h00;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cfgData", cfgData, 8'hFF);
        chk("rst_cfgValid", cfgValid, 0);
        chk("rst_xlValid", xlValid, 0);
        chk("rst_xlAddr", xlAddr, 0);
        chk("rst_xlIndex", xlIndex, 0);
        chk("rst_xlClip", xlClip, 0);

        for (int o = 0; o < 16; o++) acc({CFG, 8'(o)});
        for (int p = 0; p < 256; p++) acc({8'(p), 8'h00});

        // Linear aperture 0 and overlap with aperture 1.
        prog(0, 32'h00012345, 8'h40, 8'h4F, 8'h01);
        acc(16'h4123);
        acc(16'h5000);
        prog(1, 32'h00200000, 8'h48, 8'h5F, 8'h01);
        acc(16'h4800);
        acc(16'h5000);
        wr({CFG, 8'h0F}, 8'h00);
        acc(16'h4800);
        wr({CFG, 8'h0F}, 8'hFD);

        // 2-D aperture 2.
        prog(2, 32'h00100000, 8'h80, 8'h8F, 8'h03);
        wr({CFG, 8'h26}, 8'h02);
        wr({CFG, 8'h27}, 8'h10); wr({CFG, 8'h28}, 8'h00);
        wr({CFG, 8'h29}, 8'h03); wr({CFG, 8'h2A}, 8'h00);
        wr({CFG, 8'h2B}, 8'h40); wr({CFG, 8'h2C}, 8'h00);
        wr({CFG, 8'h2D}, 8'h04); wr({CFG, 8'h2E}, 8'h00);
        acc(16'h8105);
        acc(16'h8140);
        acc(16'h8400);
        idle(); idle();

        // Back-to-back claims, then reset one cycle after a claim.
        acc(16'h4123); acc(16'h8105); acc(16'h4FFF);
        idle(); idle();
        acc(16'h4100);
        step(1, 1, 16'h1000, 0, 0, 8'h00);
        chk("mid_rst_cfgData", cfgData, 8'hFF);
        chk("mid_rst_xlAddr", xlAddr, 0);
        idle(); idle(); idle();

        // Snapshot: in-flight translation must not see later descriptor writes.
        prog(0, 32'h00012345, 8'h40, 8'h4F, 8'h01);
        prog(1, 32'h00200000, 8'h48, 8'h5F, 8'h01);
        acc(16'h4F10);
        wr({CFG, 8'h01}, 8'h77);
        wr({CFG, 8'h05}, 8'h4E);
        acc(16'h4F10);
        acc(16'h4E10);
        idle(); idle();

        // Writes to unimplemented indices, then read the whole config page back.
        for (int o = 8'h40; o < 256; o += 7) wr({CFG, 8'(o)}, 8'($urandom));
        for (int o = 0; o < 256; o++) acc({CFG, 8'(o)});
        idle(); idle();

        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 30)
                step(0, 0, {CFG, 4'($urandom_range(0, 5)), 4'($urandom)}, 1'($urandom), 1, 8'($urandom));
            else if (r < 50)
                acc({CFG, 4'($urandom_range(0, 5)), 4'($urandom)});
            else if (r < 170)
                step(0, 1'($urandom), {8'($urandom_range(8'h38, 8'h9F)), 8'($urandom)}, 1, 1'($urandom), 8'($urandom));
            else if (r < 199)
                step(0, 0, {8'h10, 8'($urandom)}, 0, 1'($urandom), 8'($urandom));
            else
                step(1, 1, 16'h1000, 0, 0, 8'h00);
        end

        repeat (4) idle();
        chk("xl_queue_drained", xl_q.size(), 0);
        chk("cfg_queue_drained", cf_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/aperture_bank.md
# aperture_bank

Parametrised multi-channel memory-aperture unit between the A8 bus decoder and the SDRAM controller. It holds `NUM_AP` aperture descriptors, programmed through a config page. For every valid bus address it decides in the same cycle whether any enabled aperture claims that page. It then translates the address, through a two-stage pipeline, into an SDRAM byte address. Translation is either linear or a clipped 2-D window into a strided framebuffer.

## Interface
Parameters:
- `NUM_AP`, 4: number of apertures, 1..16; aperture i occupies config bytes `{CFG_PAGE, i[3:0], 4'hx}`.
- `ADDR_W`, 24: SDRAM byte-address width, 17..32.
- `CFG_PAGE`, 8'hD6: host page holding the config space.

Ports:
- `clk`  in  1  system clock
- `a8_rst`  in  1  reset; one clock, reset is synchronous and active-high
- `a8_rw_n`  in  1  A8 read(1)/write(0)
- `a8_data`  in  8  A8 data bus, valid when `wValid`
- `addr`  in  16  A8 address bus
- `aValid`  in  1  address valid strobe
- `wValid`  in  1  write data valid strobe
- `hit`  out  1  combinational: some enabled aperture claims `addr[15:8]` and `aValid`
- `hitIndex`  out  max(1,$clog2(NUM_AP))  combinational: winning aperture
- `cfgData`  out  8  config read data
- `cfgValid`  out  1  config read strobe
- `xlValid`  out  1  translation result strobe
- `xlAddr`  out  ADDR_W  translated SDRAM address
- `xlIndex`  out  as hitIndex  aperture used
- `xlClip`  out  1  2-D access outside width/height; SDRAM access must be suppressed

## Operation
- Per-aperture descriptor, by offset:
  - 0: base[31:24]. Bits ≥ ADDR_W are not stored; they read 0.
  - 1..3: base[23:0].
  - 4: lo page.
  - 5: hi page.
  - 6: stride in 256-byte pages.
  - 7/8: x, little-endian 16 bit.
  - 9/A: y, little-endian 16 bit.
  - B/C: width, little-endian 16 bit.
  - D/E: height, little-endian 16 bit.
  - F: ctrl. Bit0 is enable; bit1 is mode (0 linear, 1 2-D). Bits 7:2 are write-ignored and read 0.
- Config match: `addr[15:8]==CFG_PAGE` and `addr[7:4] < NUM_AP`. Indices ≥ NUM_AP never match; reads there produce no `cfgValid`.
- Write: when `a8_rw_n==0 && wValid && match`, update the addressed byte.
- Read: when `a8_rw_n==1 && aValid && match`, `cfgData` gets the addressed byte and `cfgValid=1` on the next cycle. Otherwise `cfgValid=0`.
- Claim: aperture i claims when `enable && lo<=page && page<=hi`. The lowest index wins among overlapping apertures. `CFG_PAGE` is never claimed. `lo>hi` claims nothing.
- Stage 1, on claim with `aValid` on either read or write: register the index, `off = addr - {lo,8'h00}` (16 bit), and the descriptor snapshot.
- Stage 2, linear mode: `xlAddr = base + off`, with `xlClip=0`.
- Stage 2, 2-D mode: `row=off[15:8]`, `col=off[7:0]`.
  - `xlClip = (col>=width) | (row>=height)`.
  - `xlAddr = base + ((y+row) * stride << 8) + x + col`.
- Arithmetic: sums are 17 bit and the product is 25 bit. Everything is zero-extended, then truncated to ADDR_W (wraps mod 2^ADDR_W).
- Translation ignores `a8_rw_n`. The pipeline accepts a new claim every cycle.

## Timing
- Reset values: all descriptors 0, including enable=0. `cfgData=8'hFF`, `cfgValid=0`, `xlValid=0`, `xlAddr=0`, `xlIndex=0`, `xlClip=0`.
- `hit`/`hitIndex` are combinational. `hitIndex=0` when `hit=0`.
- Config read latency is 1 cycle.
- Translation latency is 2 cycles: a claim in cycle T gives `xlValid=1` in T+2, for exactly one cycle per claim cycle.
- Outputs `xlAddr/xlIndex/xlClip` hold their last values when `xlValid=0`.
- Write in the same cycle as a claim: stage 1 captures the pre-write descriptor. The new value applies from the next cycle.
- `a8_rst` during an in-flight translation clears both stages. No `xlValid` is emitted after reset.
- `wValid` without a match, or `aValid` without a claim: no state change and no strobes.

## Test plan
- Reset, then read $D600..$D60F: `cfgData` is 00 for each byte except ctrl 00, `cfgValid` follows each read by 1 cycle, and `hit=0` for all pages.
- Aperture 0 linear: base=0x012345, lo=$40, hi=$4F, enable. Access $4123 gives `hit=1`, then 2 cycles later `xlAddr=0x012468`, `xlClip=0`. Access $5000 gives `hit=0`.
- Overlap: ap0 lo/hi $40-$4F, ap1 $48-$5F, both enabled. $4800 gives `hitIndex=0`; $5000 gives `hitIndex=1`; disabling ap0 makes $4800 give index 1.
- 2-D: ap2 base=0x100000, lo=$80, stride=2, x=0x10, y=3, width=0x40, height=4, mode=1. $8105 gives `xlAddr=0x100000+(4*2<<8)+0x15=0x100815`, `xlClip=0`. $8140 gives `xlClip=1`. $8400 gives `xlClip=1`.
- Back-to-back claims on consecutive cycles: three consecutive `xlValid` with the correct addresses. Assert `a8_rst` one cycle after the first claim: no `xlValid` afterwards.
- Config write to ap0 hi coincident with a claim at the old boundary: the translation uses the old descriptor, and the next-cycle claim uses the new one. Writes to index ≥ NUM_AP leave all registers unchanged.
